// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: multi-channel I2S / left-justified / TDM transmitter
// with a sample-frame FIFO. BCLK, WS and SDATA are derived from clk_clk.
//
// Ports:
//   clk_clk, reset_reset  system clock, synchronous active-high reset
//   en                    serializer enable
//   s_data/s_valid/s_ready frame write port (channel k at k*SAMPLE_WIDTH)
//   fifo_level            frames stored
//   underrun/clr_underrun sticky empty-at-load flag and its clear
//   frame_tick            one-cycle pulse per frame load
//   i2s_bclk/ws/sdata     codec pins
//   vol_shift             per-frame arithmetic attenuation
//                         (only with `define I2S_TX_VOLUME_EN)
module i2s_tx_fifo #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int BCLK_DIV     = 4,
    parameter int MODE         = 0
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset,
    input  logic                           en,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           underrun,
    input  logic                           clr_underrun,
    output logic                           frame_tick,
    output logic                           i2s_bclk,
    output logic                           i2s_ws,
    output logic                           i2s_sdata
`ifdef I2S_TX_VOLUME_EN
    ,
    input  logic [3:0]                     vol_shift
`endif
);

    localparam int FW  = NUM_CH * SAMPLE_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int DW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SLW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int CHW = $clog2(NUM_CH);

    logic [FW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  count_q;
    logic [DW-1:0]  div_q;
    logic           bclk_q;
    logic [CHW-1:0] slot_q, slot_n;
    logic [SLW-1:0] pos_q, pos_n;
    logic           first_q;
    logic [FW-1:0]  frame_q, frame_n, load_frame;
    logic           ws_q, sdata_q;
    logic           underrun_q, frame_tick_q;

    logic full, empty, wr_en, pop;
    logic wrap_div, bit_step, last_bit, load;
    logic new_bit, old_bit, ws_n, sdata_n;

    // Bit p of slot sl in the serial stream; padding bits are zero.
    function automatic logic stream_bit(
        input logic [FW-1:0]  f,
        input logic [CHW-1:0] sl,
        input logic [SLW-1:0] p
    );
        int            idx;
        logic [FW-1:0] t;
        if (int'(p) < SAMPLE_WIDTH) begin
            idx = int'(sl) * SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - int'(p);
            t = f >> idx;
            return t[0];
        end
        return 1'b0;
    endfunction

`ifdef I2S_TX_VOLUME_EN
    function automatic logic [FW-1:0] scale(
        input logic [FW-1:0] f,
        input logic [3:0]    sh
    );
        logic [FW-1:0]                  r;
        logic signed [SAMPLE_WIDTH-1:0] s;
        for (int k = 0; k < NUM_CH; k++) begin
            s = f[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            r[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s >>> sh;
        end
        return r;
    endfunction
`endif

    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign s_ready = !full && !reset_reset;
    assign wr_en   = s_valid && s_ready;

    assign wrap_div = (div_q == DW'(BCLK_DIV - 1));
    // Falling BCLK edge: divider wraps while BCLK is high.
    assign bit_step = en && wrap_div && bclk_q;
    assign last_bit = (slot_q == CHW'(NUM_CH - 1))
                   && (pos_q == SLW'(SLOT_WIDTH - 1));
    assign load     = bit_step && (first_q || last_bit);
    assign pop      = load && !empty;

`ifdef I2S_TX_VOLUME_EN
    assign load_frame = empty ? '0 : scale(mem_q[rd_ptr_q], vol_shift);
`else
    assign load_frame = empty ? '0 : mem_q[rd_ptr_q];
`endif

    always_comb begin
        slot_n = slot_q;
        pos_n  = pos_q + SLW'(1);
        if (first_q) begin
            slot_n = '0;
            pos_n  = '0;
        end else if (pos_q == SLW'(SLOT_WIDTH - 1)) begin
            pos_n  = '0;
            slot_n = (slot_q == CHW'(NUM_CH - 1)) ? '0
                                                   : slot_q + CHW'(1);
        end
    end

    assign frame_n = load ? load_frame : frame_q;
    assign new_bit = stream_bit(frame_n, slot_n, pos_n);
    // I2S delays the stream by one bit; nothing precedes a fresh start.
    assign old_bit = first_q ? 1'b0 : stream_bit(frame_q, slot_q, pos_q);
    assign sdata_n = (MODE == 1) ? new_bit : old_bit;
    assign ws_n    = (slot_n >= CHW'(NUM_CH / 2));

    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            div_q        <= '0;
            bclk_q       <= 1'b0;
            slot_q       <= '0;
            pos_q        <= '0;
            first_q      <= 1'b1;
            frame_q      <= '0;
            ws_q         <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + LW'(wr_en) - LW'(pop);

            if (load && empty) begin
                underrun_q <= 1'b1;
            end else if (clr_underrun) begin
                underrun_q <= 1'b0;
            end
            frame_tick_q <= load;

            if (!en) begin
                div_q   <= '0;
                bclk_q  <= 1'b0;
                slot_q  <= '0;
                pos_q   <= '0;
                first_q <= 1'b1;
                ws_q    <= 1'b0;
                sdata_q <= 1'b0;
            end else begin
                div_q <= wrap_div ? '0 : div_q + DW'(1);
                if (wrap_div) begin
                    bclk_q <= !bclk_q;
                end
                if (bit_step) begin
                    slot_q  <= slot_n;
                    pos_q   <= pos_n;
                    frame_q <= frame_n;
                    ws_q    <= ws_n;
                    sdata_q <= sdata_n;
                    first_q <= 1'b0;
                end
            end
        end
    end

    assign fifo_level = count_q;
    assign underrun   = underrun_q;
    assign frame_tick = frame_tick_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_ws     = ws_q;
    assign i2s_sdata  = sdata_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Testbench for i2s_tx_fifo: three instances (I2S 2ch, LJ 2ch, I2S 4ch)
// decoded from the pins and compared against a queue of expected samples.
module tb_i2s_tx_fifo;

    localparam int BD = 4;

    typedef struct {
        logic ws;
        logic sd;
        logic start;
        int   t;
    } cap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  en  = '0;
    logic [2:0]  sv  = '0;
    logic [2:0]  clr = '0;
    logic [47:0] d0  = '0;
    logic [47:0] d1  = '0;
    logic [95:0] d2  = '0;
    logic [2:0]  rdy, und, tick, bclk, ws, sd;
    logic [4:0]  lvl0, lvl1, lvl2;
`ifdef I2S_TX_VOLUME_EN
    logic [3:0]  vol = '0;
`endif

    int pass_cnt = 0;
    int tot      = 0;
    int cyc      = 0;

    cap_t        c0[$], c1[$], c2[$];
    logic [23:0] e0[$], e1[$], e2[$];

    logic [2:0]  bp, armed, pend;

    logic        f_ok, f_start;
    int          f_ws_err, f_pad_err, f_per_err;
    logic [23:0] f_v[4];
    logic [23:0] f_exp[4];

    always #5 clk = ~clk;

    i2s_tx_fifo #(.NUM_CH(2), .MODE(0)) u0 (
        .clk_clk(clk), .reset_reset(rst), .en(en[0]),
        .s_data(d0), .s_valid(sv[0]), .s_ready(rdy[0]),
        .fifo_level(lvl0), .underrun(und[0]),
        .clr_underrun(clr[0]), .frame_tick(tick[0]),
        .i2s_bclk(bclk[0]), .i2s_ws(ws[0]), .i2s_sdata(sd[0])
`ifdef I2S_TX_VOLUME_EN
        , .vol_shift(vol)
`endif
    );

    i2s_tx_fifo #(.NUM_CH(2), .MODE(1)) u1 (
        .clk_clk(clk), .reset_reset(rst), .en(en[1]),
        .s_data(d1), .s_valid(sv[1]), .s_ready(rdy[1]),
        .fifo_level(lvl1), .underrun(und[1]),
        .clr_underrun(clr[1]), .frame_tick(tick[1]),
        .i2s_bclk(bclk[1]), .i2s_ws(ws[1]), .i2s_sdata(sd[1])
`ifdef I2S_TX_VOLUME_EN
        , .vol_shift(vol)
`endif
    );

    i2s_tx_fifo #(.NUM_CH(4), .MODE(0)) u2 (
        .clk_clk(clk), .reset_reset(rst), .en(en[2]),
        .s_data(d2), .s_valid(sv[2]), .s_ready(rdy[2]),
        .fifo_level(lvl2), .underrun(und[2]),
        .clr_underrun(clr[2]), .frame_tick(tick[2]),
        .i2s_bclk(bclk[2]), .i2s_ws(ws[2]), .i2s_sdata(sd[2])
`ifdef I2S_TX_VOLUME_EN
        , .vol_shift(vol)
`endif
    );

    function automatic cap_t mk(logic w, logic s, logic st, int t);
        cap_t c;
        c.ws = w;
        c.sd = s;
        c.start = st;
        c.t = t;
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Record WS/SDATA at each rising BCLK once a frame load has been seen.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            bp[d] <= bclk[d];
            if (rst || !en[d]) begin
                armed[d] <= 1'b0;
                pend[d]  <= 1'b0;
            end else if (tick[d]) begin
                armed[d] <= 1'b1;
                pend[d]  <= 1'b1;
            end else if (armed[d] && bclk[d] && !bp[d]) begin
                case (d)
                    0: c0.push_back(mk(ws[d], sd[d], pend[d], cyc));
                    1: c1.push_back(mk(ws[d], sd[d], pend[d], cyc));
                    default: c2.push_back(mk(ws[d], sd[d], pend[d], cyc));
                endcase
                pend[d] <= 1'b0;
            end
        end
    end

    function automatic int qsize(int d);
        case (d)
            0: return c0.size();
            1: return c1.size();
            default: return c2.size();
        endcase
    endfunction

    task automatic qpop(input int d, output cap_t c);
        case (d)
            0: c = c0.pop_front();
            1: c = c1.pop_front();
            default: c = c2.pop_front();
        endcase
    endtask

    task automatic epush(input int d, input logic [23:0] v);
        case (d)
            0: e0.push_back(v);
            1: e1.push_back(v);
            default: e2.push_back(v);
        endcase
    endtask

    task automatic epop(input int d, output logic [23:0] v);
        v = 24'hxxxxxx;
        case (d)
            0: if (e0.size() > 0) v = e0.pop_front();
            1: if (e1.size() > 0) v = e1.pop_front();
            default: if (e2.size() > 0) v = e2.pop_front();
        endcase
    endtask

    task automatic drive_frame(input int d, input logic [95:0] data);
        @(negedge clk);
        case (d)
            0: d0 = data[47:0];
            1: d1 = data[47:0];
            default: d2 = data;
        endcase
        sv[d] = 1'b1;
        @(negedge clk);
        sv[d] = 1'b0;
    endtask

    task automatic write_frame(input int d, input int nch,
                               input logic [95:0] data);
        for (int k = 0; k < nch; k++) epush(d, data[k*24 +: 24]);
        drive_frame(d, data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = '0;
        sv = '0;
        clr = '0;
        @(negedge clk);
        c0.delete(); c1.delete(); c2.delete();
        e0.delete(); e1.delete(); e2.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Collect one frame of captured bits and decode it.
    task automatic get_frame(input int d, input int nch, input int mode);
        int   n, k, idx, off;
        cap_t b[$];
        cap_t x;
        logic [23:0] v;
        n = nch * 32;
        k = 0;
        off = (mode == 0) ? 1 : 0;
        f_ok = 1'b1;
        f_start = 1'b0;
        f_ws_err = 0;
        f_pad_err = 0;
        f_per_err = 0;
        for (int c = 0; c < 4; c++) begin
            f_v[c] = '0;
            f_exp[c] = '0;
        end
        for (int c = 0; c < nch; c++) epop(d, f_exp[c]);
        while (qsize(d) < n && k < n * 2 * BD + 400) begin
            @(negedge clk);
            k++;
        end
        if (qsize(d) < n) begin
            f_ok = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            qpop(d, x);
            b.push_back(x);
        end
        f_start = b[0].start;
        for (int i = 0; i < n; i++) begin
            if (b[i].ws !== (i >= n / 2)) f_ws_err++;
            if (i > 0 && b[i].start) f_ws_err++;
            if (i > 0 && b[i].t - b[i-1].t != 2 * BD) f_per_err++;
        end
        for (int c = 0; c < nch; c++) begin
            v = '0;
            for (int j = 0; j < 24; j++) v[23-j] = b[c*32 + j + off].sd;
            f_v[c] = v;
            for (int j = 24; j < 32; j++) begin
                idx = c * 32 + j + off;
                if (idx < n && b[idx].sd !== 1'b0) f_pad_err++;
            end
        end
        if (mode == 0 && b[0].sd !== 1'b0) f_pad_err++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tot++;
        if ({rdy, und, tick, bclk, ws, sd} !== 18'h0) begin
            $display("FAIL reset_outputs got %h want 0",
                     {rdy, und, tick, bclk, ws, sd});
        end else pass_cnt++;
        tot++;
        if ({lvl0, lvl1, lvl2} !== 15'h0) begin
            $display("FAIL reset_level got %h want 0", {lvl0, lvl1, lvl2});
        end else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        tot++;
        if (rdy !== 3'b111) begin
            $display("FAIL ready_after_reset got %b want 111", rdy);
        end else pass_cnt++;
    endtask

    task automatic test_i2s_frame();
        do_reset();
        write_frame(0, 2, {48'h0, 24'h800001, 24'h7FFFFE});
        @(negedge clk);
        tot++;
        if (lvl0 !== 5'd1) begin
            $display("FAIL i2s_level got %0d want 1", lvl0);
        end else pass_cnt++;
        en[0] = 1'b1;
        get_frame(0, 2, 0);
        tot++;
        if (!f_ok || f_start !== 1'b1 || f_ws_err != 0 ||
            f_per_err != 0 || f_pad_err != 0) begin
            $display("FAIL i2s_framing ok=%0b st=%0b ws=%0d per=%0d pad=%0d want 1 1 0 0 0",
                     f_ok, f_start, f_ws_err, f_per_err, f_pad_err);
        end else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            tot++;
            if (f_v[c] !== f_exp[c]) begin
                $display("FAIL i2s_ch%0d got %h want %h", c, f_v[c], f_exp[c]);
            end else pass_cnt++;
        end
        tot++;
        if (und[0] !== 1'b0) begin
            $display("FAIL i2s_no_underrun got %b want 0", und[0]);
        end else pass_cnt++;
        epush(0, 24'h0);
        epush(0, 24'h0);
        get_frame(0, 2, 0);
        tot++;
        if (!f_ok || f_v[0] !== 24'h0 || f_v[1] !== 24'h0 ||
            und[0] !== 1'b1) begin
            $display("FAIL i2s_empty_frame got %h %h und=%b want 0 0 und=1",
                     f_v[0], f_v[1], und[0]);
        end else pass_cnt++;
        en[0] = 1'b0;
    endtask

    task automatic test_lj_frame();
        do_reset();
        write_frame(1, 2, {48'h0, 24'h800001, 24'h7FFFFE});
        en[1] = 1'b1;
        get_frame(1, 2, 1);
        tot++;
        if (!f_ok || f_start !== 1'b1 || f_ws_err != 0 ||
            f_per_err != 0 || f_pad_err != 0) begin
            $display("FAIL lj_framing ok=%0b st=%0b ws=%0d per=%0d pad=%0d want 1 1 0 0 0",
                     f_ok, f_start, f_ws_err, f_per_err, f_pad_err);
        end else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            tot++;
            if (f_v[c] !== f_exp[c]) begin
                $display("FAIL lj_ch%0d got %h want %h", c, f_v[c], f_exp[c]);
            end else pass_cnt++;
        end
        en[1] = 1'b0;
    endtask

    task automatic test_tdm4();
        do_reset();
        write_frame(2, 4, {24'd4, 24'd3, 24'd2, 24'd1});
        en[2] = 1'b1;
        get_frame(2, 4, 0);
        tot++;
        if (!f_ok || f_start !== 1'b1 || f_ws_err != 0 ||
            f_per_err != 0 || f_pad_err != 0) begin
            $display("FAIL tdm_framing ok=%0b st=%0b ws=%0d per=%0d pad=%0d want 1 1 0 0 0",
                     f_ok, f_start, f_ws_err, f_per_err, f_pad_err);
        end else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            tot++;
            if (f_v[c] !== f_exp[c]) begin
                $display("FAIL tdm_ch%0d got %h want %h", c, f_v[c], f_exp[c]);
            end else pass_cnt++;
        end
        en[2] = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            write_frame(0, 2, {48'h0, 24'hA00000 + 24'(k),
                               24'h050000 + 24'(k)});
        end
        @(negedge clk);
        tot++;
        if (lvl0 !== 5'd16 || rdy[0] !== 1'b0) begin
            $display("FAIL full_level got lvl=%0d rdy=%b want 16 0",
                     lvl0, rdy[0]);
        end else pass_cnt++;
        drive_frame(0, {48'h0, 48'hDEADBEEF0123});
        @(negedge clk);
        tot++;
        if (lvl0 !== 5'd16) begin
            $display("FAIL full_reject got %0d want 16", lvl0);
        end else pass_cnt++;
        en[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            get_frame(0, 2, 0);
            tot++;
            if (!f_ok || f_v[0] !== f_exp[0] || f_v[1] !== f_exp[1]) begin
                $display("FAIL full_frame%0d got %h %h want %h %h",
                         k, f_v[0], f_v[1], f_exp[0], f_exp[1]);
            end else pass_cnt++;
            tot++;
            if (lvl0 !== 5'(15 - k)) begin
                $display("FAIL full_drain%0d got %0d want %0d",
                         k, lvl0, 15 - k);
            end else pass_cnt++;
        end
        epush(0, 24'h0);
        epush(0, 24'h0);
        get_frame(0, 2, 0);
        tot++;
        if (!f_ok || f_v[0] !== 24'h0 || f_v[1] !== 24'h0 ||
            und[0] !== 1'b1) begin
            $display("FAIL full_after_drain got %h %h und=%b want 0 0 und=1",
                     f_v[0], f_v[1], und[0]);
        end else pass_cnt++;
        en[0] = 1'b0;
    endtask

    task automatic test_underrun();
        int k;
        do_reset();
        en[0] = 1'b1;
        k = 0;
        while (tick[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        tot++;
        if (tick[0] !== 1'b1 || und[0] !== 1'b1) begin
            $display("FAIL ur_first_load got tick=%b und=%b want 1 1",
                     tick[0], und[0]);
        end else pass_cnt++;
        epush(0, 24'h0);
        epush(0, 24'h0);
        get_frame(0, 2, 0);
        tot++;
        if (!f_ok || f_v[0] !== 24'h0 || f_v[1] !== 24'h0 ||
            f_pad_err != 0) begin
            $display("FAIL ur_zero_frame got %h %h pad=%0d want 0 0 0",
                     f_v[0], f_v[1], f_pad_err);
        end else pass_cnt++;
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        tot++;
        if (und[0] !== 1'b0) begin
            $display("FAIL ur_clear got %b want 0", und[0]);
        end else pass_cnt++;
        k = 0;
        while (tick[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        tot++;
        if (tick[0] !== 1'b1 || und[0] !== 1'b1) begin
            $display("FAIL ur_set_priority got tick=%b und=%b want 1 1",
                     tick[0], und[0]);
        end else pass_cnt++;
        clr[0] = 1'b0;
        @(negedge clk);
        tot++;
        if (und[0] !== 1'b1) begin
            $display("FAIL ur_sticky got %b want 1", und[0]);
        end else pass_cnt++;
        en[0] = 1'b0;
    endtask

    task automatic test_en_drop();
        int k;
        do_reset();
        drive_frame(0, {48'h0, 24'h111111, 24'h222222});
        write_frame(0, 2, {48'h0, 24'h654321, 24'h0ABCDE});
        en[0] = 1'b1;
        k = 0;
        while (c0.size() < 20 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        en[0] = 1'b0;
        @(negedge clk);
        tot++;
        if ({bclk[0], ws[0], sd[0]} !== 3'b000 || lvl0 !== 5'd1) begin
            $display("FAIL en_drop_idle got pins=%b lvl=%0d want 000 1",
                     {bclk[0], ws[0], sd[0]}, lvl0);
        end else pass_cnt++;
        c0.delete();
        en[0] = 1'b1;
        get_frame(0, 2, 0);
        tot++;
        if (!f_ok || f_start !== 1'b1 || f_v[0] !== f_exp[0] ||
            f_v[1] !== f_exp[1]) begin
            $display("FAIL en_drop_restart got %h %h want %h %h",
                     f_v[0], f_v[1], f_exp[0], f_exp[1]);
        end else pass_cnt++;
        en[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) drive_frame(0, {48'h0, 48'(k + 5)});
        en[0] = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tot++;
        if ({rdy[0], und[0], tick[0], bclk[0], ws[0], sd[0]} !== 6'h0 ||
            lvl0 !== 5'd0) begin
            $display("FAIL reset_mid got %b lvl=%0d want 0 0",
                     {rdy[0], und[0], tick[0], bclk[0], ws[0], sd[0]}, lvl0);
        end else pass_cnt++;
        rst = 1'b0;
        en[0] = 1'b0;
        @(negedge clk);
        tot++;
        if (rdy[0] !== 1'b1 || lvl0 !== 5'd0) begin
            $display("FAIL reset_mid_release got rdy=%b lvl=%0d want 1 0",
                     rdy[0], lvl0);
        end else pass_cnt++;
    endtask

`ifdef I2S_TX_VOLUME_EN
    task automatic test_volume();
        do_reset();
        vol = 4'd4;
        drive_frame(0, {48'h0, 24'h123456, 24'hF00000});
        epush(0, 24'hFF0000);
        epush(0, 24'h012345);
        en[0] = 1'b1;
        get_frame(0, 2, 0);
        for (int c = 0; c < 2; c++) begin
            tot++;
            if (!f_ok || f_v[c] !== f_exp[c]) begin
                $display("FAIL volume_ch%0d got %h want %h",
                         c, f_v[c], f_exp[c]);
            end else pass_cnt++;
        end
        en[0] = 1'b0;
        vol = 4'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_i2s_frame();
        test_lj_frame();
        test_tdm4();
        test_fifo_full();
        test_underrun();
        test_en_drop();
        test_reset_mid();
`ifdef I2S_TX_VOLUME_EN
        test_volume();
`endif
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end

endmodule
